alt_vipswi131_common_avalon_mm_cfg_master: RTL and testbench

Avalon-MM master that programs and supervises a VIP core's standard control slave. The slave's register map is:

- 0: control (go bit 0, interrupt enables above it)
- 1: status (stopped bit 0)
- 2: interrupt (write-1-to-clear)
- 3 and up: parameter registers

The master sits in the switch subsystem between the internal scheduler and each downstream core's control port. It turns single-cycle internal commands into the correct sequence of Avalon-MM reads and writes: load parameters and start, stop and wait for stopped, and service and clear interrupts.

---
 rtl/alt_vipswi131_common_avalon_mm_cfg_master_pkg.sv | 38 +++
 rtl/alt_vipswi131_common_avalon_mm_cfg_master.sv | 200 ++++++++++++++++++++
 tb/tb_alt_vipswi131_common_avalon_mm_cfg_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_vipswi131_common_avalon_mm_cfg_master_pkg.sv
// ============================================================================
// alt_vipswi131_common_avalon_mm_cfg_master_pkg
// Register map, bit positions and state encodings for the control-port master.
// Rev 1.0
// ============================================================================
`default_nettype none

package alt_vipswi131_common_avalon_mm_cfg_master_pkg;

  // Standard VIP control slave register map
  localparam int CTRL       = 0;
  localparam int STATUS     = 1;
  localparam int INTR       = 2;
  localparam int PARAM_BASE = 3;

  localparam int GO      = 0;
  localparam int STOPPED = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REGS  = 3'd1,
    WR_CTRL  = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    POLL_GAP = 3'd5,
    WR_CLR   = 3'd6,
    FINISH   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SEQ_START = 2'd0,
    SEQ_STOP  = 2'd1,
    SEQ_IRQ   = 2'd2
  } seq_t;

endpackage

`default_nettype wire

// File: rtl/alt_vipswi131_common_avalon_mm_cfg_master.sv
// ============================================================================
// alt_vipswi131_common_avalon_mm_cfg_master
// Sequences start / stop / irq-service transfers onto a VIP core control slave.
// Rev 1.0
// ============================================================================
`default_nettype none

module alt_vipswi131_common_avalon_mm_cfg_master
  import alt_vipswi131_common_avalon_mm_cfg_master_pkg::*;
#(
  parameter int AV_ADDRESS_WIDTH = 5,
  parameter int AV_DATA_WIDTH    = 16,
  parameter int NO_REGISTERS     = 4,
  parameter int NO_INTERRUPTS    = 1,
  parameter int READ_LATENCY     = 1,
  parameter int POLL_INTERVAL    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  output logic [AV_ADDRESS_WIDTH-1:0]             av_address,
  output logic                                    av_read,
  input  logic [AV_DATA_WIDTH-1:0]                av_readdata,
  output logic                                    av_write,
  output logic [AV_DATA_WIDTH-1:0]                av_writedata,
  input  logic                                    av_waitrequest,
  input  logic                                    av_irq,
  input  logic                                    cmd_start,
  input  logic                                    cmd_stop,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0]   cmd_registers,
  input  logic [NO_INTERRUPTS-1:0]                cmd_int_enables,
  output logic                                    busy,
  output logic                                    done,
  output logic [NO_INTERRUPTS-1:0]                irq_status,
  output logic                                    irq_valid
);

  localparam int IDX_W   = (NO_REGISTERS > 1) ? $clog2(NO_REGISTERS) : 1;
  localparam int CNT_MAX = (READ_LATENCY > POLL_INTERVAL) ? READ_LATENCY : POLL_INTERVAL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AW      = AV_ADDRESS_WIDTH;
  localparam int DW      = AV_DATA_WIDTH;

  state_t                        state;
  seq_t                          seq;
  logic [IDX_W-1:0]              idx;
  logic [CNT_W-1:0]              cnt;
  logic [DW*NO_REGISTERS-1:0]    regs;
  logic [NO_INTERRUPTS-1:0]      enables;
  logic [NO_INTERRUPTS-1:0]      irq_hold;

  logic [DW-1:0]                 start_ctrl;
  logic [DW-1:0]                 stop_ctrl;
  logic [DW-1:0]                 irq_clr;
  logic                          read_done;
  logic                          irq_sample;

  // Only the status and serviced interrupt fields of read data are consumed.
  wire unused_readdata = &{1'b0, av_readdata};

  always_comb begin
    start_ctrl                   = '0;
    start_ctrl[NO_INTERRUPTS:1]  = enables;
    start_ctrl[GO]               = 1'b1;
    stop_ctrl                    = '0;
    stop_ctrl[NO_INTERRUPTS:1]   = cmd_int_enables;
    irq_clr                      = '0;
    irq_clr[NO_INTERRUPTS:1]     = av_readdata[NO_INTERRUPTS:1];
  end

  assign read_done  = (state == RD_WAIT) && (cnt == CNT_W'(READ_LATENCY));
  assign irq_sample = read_done && (seq == SEQ_IRQ);

  // The serviced bits are presented in the cycle the read data is sampled,
  // so irq_valid lines up with that cycle rather than one cycle later.
  assign irq_valid  = irq_sample;
  assign irq_status = irq_sample ? av_readdata[NO_INTERRUPTS:1] : irq_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      seq          <= SEQ_START;
      idx          <= '0;
      cnt          <= '0;
      regs         <= '0;
      enables      <= '0;
      irq_hold     <= '0;
      av_address   <= '0;
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_writedata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_stop) begin
            seq          <= SEQ_STOP;
            state        <= WR_CTRL;
            av_write     <= 1'b1;
            av_address   <= AW'(CTRL);
            av_writedata <= stop_ctrl;
            busy         <= 1'b1;
          end else if (cmd_start) begin
            seq          <= SEQ_START;
            regs         <= cmd_registers;
            enables      <= cmd_int_enables;
            idx          <= '0;
            state        <= WR_REGS;
            av_write     <= 1'b1;
            av_address   <= AW'(PARAM_BASE);
            av_writedata <= cmd_registers[DW-1:0];
            busy         <= 1'b1;
          end else if (av_irq) begin
            seq        <= SEQ_IRQ;
            state      <= RD_REQ;
            av_read    <= 1'b1;
            av_address <= AW'(INTR);
            busy       <= 1'b1;
          end
        end
        WR_REGS: begin
          if (!av_waitrequest) begin
            if (idx == IDX_W'(NO_REGISTERS - 1)) begin
              state        <= WR_CTRL;
              av_address   <= AW'(CTRL);
              av_writedata <= start_ctrl;
            end else begin
              idx          <= idx + 1'b1;
              av_address   <= AW'(PARAM_BASE) + AW'(idx) + AW'(1);
              av_writedata <= regs[(int'(idx) + 1) * DW +: DW];
            end
          end
        end
        WR_CTRL: begin
          if (!av_waitrequest) begin
            av_write <= 1'b0;
            if (seq == SEQ_STOP) begin
              state      <= RD_REQ;
              av_read    <= 1'b1;
              av_address <= AW'(STATUS);
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (!av_waitrequest) begin
            av_read <= 1'b0;
            cnt     <= CNT_W'(1);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (read_done) begin
            if (seq == SEQ_IRQ) begin
              irq_hold     <= av_readdata[NO_INTERRUPTS:1];
              state        <= WR_CLR;
              av_write     <= 1'b1;
              av_address   <= AW'(INTR);
              av_writedata <= irq_clr;
            end else if (av_readdata[STOPPED]) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              cnt   <= CNT_W'(1);
              state <= POLL_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        POLL_GAP: begin
          if (cnt == CNT_W'(POLL_INTERVAL)) begin
            state   <= RD_REQ;
            av_read <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_CLR: begin
          if (!av_waitrequest) begin
            av_write <= 1'b0;
            state    <= FINISH;
            done     <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alt_vipswi131_common_avalon_mm_cfg_master.sv
// ============================================================================
// tb_alt_vipswi131_common_avalon_mm_cfg_master
// Directed + randomized bench with a slave model and transaction-level reference.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alt_vipswi131_common_avalon_mm_cfg_master;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int NI = 1;
  localparam int RL = 1;
  localparam int PI = 16;
  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_IRQ   = 2;

  typedef struct {
    bit wr;
    int addr;
    int data;
    int cyc;
  } tx_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     av_address;
  logic              av_read;
  logic [DW-1:0]     av_readdata;
  logic              av_write;
  logic [DW-1:0]     av_writedata;
  logic              av_waitrequest;
  logic              av_irq;
  logic              cmd_start;
  logic              cmd_stop;
  logic [DW*NR-1:0]  cmd_registers;
  logic [NI-1:0]     cmd_int_enables;
  logic              busy;
  logic              done;
  logic [NI-1:0]     irq_status;
  logic              irq_valid;

  alt_vipswi131_common_avalon_mm_cfg_master #(
    .AV_ADDRESS_WIDTH (AW),
    .AV_DATA_WIDTH    (DW),
    .NO_REGISTERS     (NR),
    .NO_INTERRUPTS    (NI),
    .READ_LATENCY     (RL),
    .POLL_INTERVAL    (PI)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .av_address      (av_address),
    .av_read         (av_read),
    .av_readdata     (av_readdata),
    .av_write        (av_write),
    .av_writedata    (av_writedata),
    .av_waitrequest  (av_waitrequest),
    .av_irq          (av_irq),
    .cmd_start       (cmd_start),
    .cmd_stop        (cmd_stop),
    .cmd_registers   (cmd_registers),
    .cmd_int_enables (cmd_int_enables),
    .busy            (busy),
    .done            (done),
    .irq_status      (irq_status),
    .irq_valid       (irq_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors = 0;
  int errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave model state
  int        stall_pct = 0;
  int        hold_addr = -1;
  int        hold_left = 0;
  bit        status_q[$];
  logic [DW-1:0] irq_reg = '0;
  bit        rd_pending = 0;
  int        rd_due = 0;
  logic [DW-1:0] rd_value = '0;

  // Observation state
  tx_t       txq[$];
  tx_t       expq[$];
  int        done_cnt, done_cyc, busy_cnt, iv_cnt, iv_cyc;
  logic [NI-1:0] iv_status;
  bit        prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    logic wreq;
    logic [DW-1:0] v;
    wreq = 1'b0;
    if (!rst && (av_read || av_write)) begin
      if (hold_left > 0 && int'(av_address) == hold_addr) begin
        wreq = 1'b1;
        hold_left--;
      end else if ($urandom_range(0, 99) < stall_pct) begin
        wreq = 1'b1;
      end
    end
    av_waitrequest = wreq;
    av_readdata = (rd_pending && cyc == rd_due) ? rd_value : DW'($urandom);
    if (rd_pending && cyc == rd_due) rd_pending = 0;
    #1;
    if (!rst) begin
      if (av_read || av_write) begin
        check_eq("rw_exclusive", {31'd0, av_read & av_write}, 32'd0);
        if (prev_stall) begin
          check_eq("addr_stable", 32'(av_address), 32'(prev_addr));
          if (av_write) check_eq("data_stable", 32'(av_writedata), 32'(prev_data));
        end
      end
      if (av_read && !wreq) begin
        if (int'(av_address) == 1) begin
          v = DW'($urandom);
          v[0] = (status_q.size() > 0) ? status_q.pop_front() : 1'b1;
        end else begin
          v = irq_reg;
        end
        txq.push_back('{wr: 0, addr: int'(av_address), data: 0, cyc: cyc});
        rd_pending = 1;
        rd_due = cyc + RL;
        rd_value = v;
      end
      if (av_write && !wreq)
        txq.push_back('{wr: 1, addr: int'(av_address), data: int'(av_writedata), cyc: cyc});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (irq_valid) begin
        iv_cnt++;
        iv_cyc = cyc;
        iv_status = irq_status;
      end
      prev_stall = wreq && (av_read || av_write);
      prev_addr = av_address;
      prev_data = av_writedata;
    end else begin
      prev_stall = 0;
    end
  end

  // Reference: the transfer list each command must produce on the bus
  task automatic build_expected(input int kind, input logic [DW*NR-1:0] regs,
                                input logic [NI-1:0] en, input int nzeros,
                                input logic [DW-1:0] irqv);
    int mask;
    expq.delete();
    mask = ((1 << NI) - 1) << 1;
    if (kind == K_START) begin
      for (int i = 0; i < NR; i++)
        expq.push_back('{wr: 1, addr: 3 + i, data: int'(regs[i*DW +: DW]), cyc: 0});
      expq.push_back('{wr: 1, addr: 0, data: (int'(en) << 1) | 1, cyc: 0});
    end else if (kind == K_STOP) begin
      expq.push_back('{wr: 1, addr: 0, data: int'(en) << 1, cyc: 0});
      for (int i = 0; i <= nzeros; i++)
        expq.push_back('{wr: 0, addr: 1, data: 0, cyc: 0});
    end else begin
      expq.push_back('{wr: 0, addr: 2, data: 0, cyc: 0});
      expq.push_back('{wr: 1, addr: 2, data: int'(irqv) & mask, cyc: 0});
    end
  endtask

  int c0;

  task automatic run_cmd(input string tag, input int kind, input logic [DW*NR-1:0] regs,
                         input logic [NI-1:0] en, input int nzeros, input logic [DW-1:0] irqv,
                         input bit with_start, input int busy_start_at);
    int n;
    build_expected(kind, regs, en, nzeros, irqv);
    status_q.delete();
    for (int i = 0; i < nzeros; i++) status_q.push_back(1'b0);
    status_q.push_back(1'b1);
    irq_reg = irqv;
    @(posedge clk); #1;
    txq.delete();
    done_cnt = 0; busy_cnt = 0; iv_cnt = 0; done_cyc = 0; iv_cyc = 0;
    c0 = cyc;
    cmd_registers   = regs;
    cmd_int_enables = en;
    cmd_start = (kind == K_START) || with_start;
    cmd_stop  = (kind == K_STOP);
    av_irq    = (kind == K_IRQ);
    @(posedge clk); #1;
    cmd_start = 0; cmd_stop = 0; av_irq = 0;
    cmd_registers   = {($urandom), ($urandom)};
    cmd_int_enables = NI'($urandom);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      cmd_start = (busy_start_at > 0 && cyc == c0 + busy_start_at);
    end
    cmd_start = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, ":done_count"}, 32'(done_cnt), 32'd1);
    check_eq({tag, ":n_transfers"}, 32'(txq.size()), 32'(expq.size()));
    n = (txq.size() < expq.size()) ? txq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, ":dir"}, 32'(txq[i].wr), 32'(expq[i].wr));
      check_eq({tag, ":addr"}, 32'(txq[i].addr), 32'(expq[i].addr));
      if (expq[i].wr) check_eq({tag, ":wdata"}, 32'(txq[i].data), 32'(expq[i].data));
    end
    if (done_cnt == 1) begin
      check_eq({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(done_cyc - c0));
      if (txq.size() > 0) begin
        if (kind == K_STOP)
          check_eq({tag, ":done_after_read"}, 32'(done_cyc), 32'(txq[txq.size()-1].cyc + RL + 1));
        else
          check_eq({tag, ":done_after_write"}, 32'(done_cyc), 32'(txq[txq.size()-1].cyc + 1));
      end
    end
    if (kind == K_IRQ) begin
      check_eq({tag, ":irq_valid_count"}, 32'(iv_cnt), 32'd1);
      check_eq({tag, ":irq_status"}, 32'(iv_status), 32'(irqv[NI:1]));
      if (txq.size() > 0)
        check_eq({tag, ":irq_valid_cycle"}, 32'(iv_cyc), 32'(txq[0].cyc + RL));
    end else begin
      check_eq({tag, ":irq_valid_count"}, 32'(iv_cnt), 32'd0);
    end
  endtask

  initial begin
    logic [DW*NR-1:0] regs;
    regs = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    rst = 1; av_irq = 0; cmd_start = 0; cmd_stop = 0;
    cmd_registers = '0; cmd_int_enables = '0;
    av_waitrequest = 0; av_readdata = '0;
    #1;
    check_eq("reset_outputs", {av_read, av_write, busy, done, irq_valid, irq_status,
                               av_address, av_writedata}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Start, no stalls: exact cycle timing
    run_cmd("start", K_START, regs, 1'b1, 0, '0, 0, 0);
    if (txq.size() == 5) begin
      check_eq("start:first_write_cycle", 32'(txq[0].cyc), 32'(c0 + 1));
      check_eq("start:ctrl_write_cycle", 32'(txq[4].cyc), 32'(c0 + 5));
    end
    check_eq("start:done_cycle", 32'(done_cyc), 32'(c0 + 6));

    // Three stall cycles on the second parameter write
    hold_addr = 4; hold_left = 3;
    run_cmd("stall", K_START, regs, 1'b1, 0, '0, 0, 0);
    if (txq.size() == 5) check_eq("stall:addr4_cycle", 32'(txq[1].cyc), 32'(c0 + 5));
    check_eq("stall:done_cycle", 32'(done_cyc), 32'(c0 + 9));
    hold_addr = -1; hold_left = 0;

    // Stop with start in the same cycle and again while busy; polls 0,0,1
    run_cmd("stop", K_STOP, regs, 1'b1, 2, '0, 1'b1, 5);
    if (txq.size() == 4) begin
      check_eq("stop:read1_cycle", 32'(txq[1].cyc), 32'(c0 + 2));
      check_eq("stop:poll_gap_a", 32'(txq[2].cyc - txq[1].cyc), 32'(PI + 1 + RL));
      check_eq("stop:poll_gap_b", 32'(txq[3].cyc - txq[2].cyc), 32'(PI + 1 + RL));
    end

    // Immediately-stopped core
    run_cmd("stop0", K_STOP, regs, 1'b0, 0, '0, 1'b0, 0);
    check_eq("stop0:done_cycle", 32'(done_cyc), 32'(c0 + 4));

    // Interrupt service with register 2 = 0x0002
    run_cmd("irq", K_IRQ, regs, 1'b1, 0, 16'h0002, 1'b0, 0);
    check_eq("irq:done_cycle", 32'(done_cyc), 32'(c0 + RL + 3));

    // Reset in the middle of WR_REGS, then a clean start
    @(posedge clk); #1;
    cmd_start = 1; cmd_registers = regs; cmd_int_enables = 1'b1;
    @(posedge clk); #1;
    cmd_start = 0;
    @(posedge clk); #3;
    rst = 1;
    #1;
    check_eq("midreset_outputs", {av_read, av_write, busy, done, irq_valid, irq_status,
                                  av_address, av_writedata}, '0);
    @(posedge clk); #1;
    rst = 0;
    run_cmd("after_reset", K_START, regs, 1'b1, 0, '0, 0, 0);

    // Randomized commands with random slave stalls
    stall_pct = 30;
    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 2);
      run_cmd("rand", k, {($urandom), ($urandom)}, NI'($urandom),
              $urandom_range(0, 2), DW'($urandom), 1'b0, 0);
    end
    stall_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
